// File: rtl/sha_256_pkg.sv
// Shared constants and types for the SHA-256 front end.
// Imported by the padder and its block buffer.
package sha_256_pkg;

  localparam int BLOCK_W         = 512;
  localparam int BYTES_PER_BLOCK = 64;
  localparam int LEN_BYTE_OFS    = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEND_DATA,
    ST_SEND_PAD,
    ST_SEND_FINAL
  } pad_state_e;

endpackage

// File: rtl/sha_256_pad_buffer.sv
// 512-bit byte-addressed block register for the padder.
// Byte 0 sits in the most significant byte of the block.
module sha_256_pad_buffer
  import sha_256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [5:0]         wr_idx,
  input  logic [7:0]         wr_byte,
  input  logic               pad_en,
  input  logic [5:0]         pad_idx,
  input  logic               len_en,
  input  logic [63:0]        len_val,
  output logic [BLOCK_W-1:0] data
);

  logic [BYTES_PER_BLOCK-1:0][7:0] buf_q;
  logic [BYTES_PER_BLOCK-1:0][7:0] buf_d;

  // Byte i lives at packed slot 63-i, i.e. ~i.
  always_comb begin
    buf_d = buf_q;
    if (clr) begin
      buf_d = '0;
    end
    if (wr_en) begin
      buf_d[~wr_idx] = wr_byte;
    end
    if (pad_en) begin
      buf_d[~pad_idx] = PAD_BYTE;
    end
    if (len_en) begin
      buf_d[7:0] = len_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign data = buf_q;

endmodule

// File: rtl/sha_256_padder.sv
// FIPS 180-4 message padder: byte stream in, 512-bit blocks out.
// Owns the FSM, byte index, bit length and both handshakes.
module sha_256_padder
  import sha_256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  input  logic               in_keep,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last
);

  pad_state_e state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pend80_q, pend80_d;
  logic             first_q, first_d;
  logic             in_ready_q, in_ready_d;
  logic             blk_valid_q, blk_valid_d;

  logic             clr;
  logic             wr_en;
  logic             pad_en;
  logic [5:0]       pad_idx;
  logic             len_en;
  logic [63:0]      len_ins;
  logic             in_fire;
  logic             blk_fire;
  logic             counted;
  logic [6:0]       n;
  logic [LEN_W-1:0] len_inc;

  assign in_fire  = in_valid & in_ready_q;
  assign blk_fire = blk_valid_q & blk_ready;
  assign counted  = ~in_last | in_keep;
  assign n        = {1'b0, idx_q} + 7'(counted);
  assign len_inc  = len_q + (counted ? LEN_W'(8) : '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    pend80_d = pend80_q;
    first_d  = first_q;
    clr      = 1'b0;
    wr_en    = 1'b0;
    pad_en   = 1'b0;
    pad_idx  = '0;
    len_en   = 1'b0;
    len_ins  = 64'(len_q);
    unique case (state_q)
      ST_FILL: begin
        if (in_fire) begin
          wr_en = counted;
          idx_d = n[5:0];
          len_d = len_inc;
          if (!in_last) begin
            if (n == 7'd64) begin
              state_d = ST_SEND_DATA;
            end
          end else if (n <= 7'd55) begin
            pad_en  = 1'b1;
            pad_idx = n[5:0];
            len_en  = 1'b1;
            len_ins = 64'(len_inc);
            state_d = ST_SEND_FINAL;
          end else if (n < 7'd64) begin
            pad_en  = 1'b1;
            pad_idx = n[5:0];
            state_d = ST_SEND_PAD;
          end else begin
            pend80_d = 1'b1;
            state_d  = ST_SEND_PAD;
          end
        end
      end
      ST_SEND_DATA: begin
        if (blk_fire) begin
          clr     = 1'b1;
          idx_d   = '0;
          first_d = 1'b0;
          state_d = ST_FILL;
        end
      end
      ST_SEND_PAD: begin
        // Clear and rebuild as the closing length block.
        if (blk_fire) begin
          clr     = 1'b1;
          pad_en  = pend80_q;
          len_en  = 1'b1;
          first_d = 1'b0;
          state_d = ST_SEND_FINAL;
        end
      end
      ST_SEND_FINAL: begin
        if (blk_fire) begin
          clr      = 1'b1;
          idx_d    = '0;
          len_d    = '0;
          first_d  = 1'b1;
          pend80_d = 1'b0;
          state_d  = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    in_ready_d  = (state_d == ST_FILL);
    blk_valid_d = (state_d != ST_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      len_q       <= '0;
      pend80_q    <= 1'b0;
      first_q     <= 1'b1;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pend80_q    <= pend80_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  sha_256_pad_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_byte (in_data),
    .pad_en  (pad_en),
    .pad_idx (pad_idx),
    .len_en  (len_en),
    .len_val (len_ins),
    .data    (blk_data)
  );

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_first = blk_valid_q & first_q;
  assign blk_last  = blk_valid_q & (state_q == ST_SEND_FINAL);

endmodule

// File: tb/tb_sha_256_padder.sv
// Self-checking bench for sha_256_padder.
// Reference padding model feeds a block scoreboard.
module tb_sha_256_padder;
  import sha_256_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_keep;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  always #5 clk = ~clk;

  sha_256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_keep   (in_keep),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  typedef struct {
    int           len;
    logic [7:0]   base;
    int           step;
    int           nblk;
    logic         lit_en;
    logic [511:0] lit;
  } vec_t;

  typedef byte unsigned bq_t[$];

  blk_t         exp_q[$];
  blk_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           rx_blocks = 0;
  logic [511:0] last_rx = '0;

  localparam logic [511:0] ABC_BLK =
    {32'h61626380, 416'b0, 64'h18};

  task automatic chk(input string name,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic got,
                      input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block got=%h exp=none", blk_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("blk_data", blk_data, mon_e.data);
        chk1("blk_first", blk_first, mon_e.first);
        chk1("blk_last", blk_last, mon_e.last);
      end
      last_rx = blk_data;
      rx_blocks++;
    end
  end

  task automatic push_model(input bq_t msg);
    bq_t p;
    logic [63:0] bits;
    blk_t b;
    int nb;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++)
        b.data[511 - 8*j -: 8] = p[64*k + j];
      b.first = (k == 0);
      b.last  = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d,
                            input logic last,
                            input logic keep);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_keep  = keep;
    while (!in_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg);
    if (msg.size() == 0) begin
      drive_beat(8'hff, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < msg.size(); i++) begin
        if (i == msg.size() - 1)
          drive_beat(msg[i], 1'b1, 1'b1);
        else
          drive_beat(msg[i], 1'b0, 1'($urandom_range(1)));
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_abc();
    bq_t m;
    m = '{8'h61, 8'h62, 8'h63};
    push_model(m);
    send_msg(m);
    drain();
    chk("abc_block", last_rx, ABC_BLK);
  endtask

  vec_t vecs[8];
  bq_t  msg;
  logic [511:0] held;
  int   rx0;

  initial begin
    vecs[0] = '{55, 8'h00, 0, 1, 1'b1, {440'b0, 8'h80, 64'h1b8}};
    vecs[1] = '{56, 8'h00, 0, 2, 1'b1, {448'b0, 64'h1c0}};
    vecs[2] = '{64, 8'h00, 0, 2, 1'b1, {8'h80, 440'b0, 64'h200}};
    vecs[3] = '{1, 8'h5a, 0, 1, 1'b0, '0};
    vecs[4] = '{63, 8'h01, 1, 2, 1'b0, '0};
    vecs[5] = '{65, 8'h10, 3, 2, 1'b0, '0};
    vecs[6] = '{120, 8'h00, 1, 3, 1'b0, '0};
    vecs[7] = '{128, 8'hc3, 7, 3, 1'b0, '0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_keep = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_data", blk_data, '0);
    chk1("rst_blk_first", blk_first, 1'b0);
    chk1("rst_blk_last", blk_last, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk1("in_ready_pre_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    chk1("in_ready_post_edge", in_ready, 1'b1);

    run_abc();

    msg.delete();
    push_model(msg);
    send_msg(msg);
    drain();
    chk("empty_block", last_rx, {8'h80, 504'b0});

    for (int v = 0; v < 8; v++) begin
      msg.delete();
      for (int i = 0; i < vecs[v].len; i++)
        msg.push_back(8'(int'(vecs[v].base) + vecs[v].step * i));
      rx0 = rx_blocks;
      push_model(msg);
      send_msg(msg);
      drain();
      chk("nblk", 512'(rx_blocks - rx0), 512'(vecs[v].nblk));
      if (vecs[v].lit_en)
        chk("final_literal", last_rx, vecs[v].lit);
    end

    blk_ready = 1'b0;
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h00);
    push_model(msg);
    send_msg(msg);
    chk1("bp_valid", blk_valid, 1'b1);
    held = blk_data;
    in_valid = 1'b1;
    in_data = 8'haa;
    in_last = 1'b0;
    in_keep = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_hold_valid", blk_valid, 1'b1);
      chk("bp_hold_data", blk_data, held);
    end
    in_valid = 1'b0;
    blk_ready = 1'b1;
    drain();
    run_abc();

    msg.delete();
    for (int i = 0; i < 30; i++) drive_beat(8'(i + 1), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_blk_valid", blk_valid, 1'b0);
    chk("midrst_blk_data", blk_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("midrst_ready_back", in_ready, 1'b1);
    run_abc();

    chk("scoreboard_empty", 512'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
